// File: rtl/cpm5_cq_rx_pkg.sv
// Shared types and widths for the CPM5 CQ credit receiver.
package cpm5_cq_rx_pkg;

    localparam int CQ_DATA_W     = 1024;
    localparam int CQ_USER_W     = 466;
    localparam int CQ_KEEP_W     = 32;
    localparam int CQ_CRED_DEPTH = 16;

    typedef struct packed {
        logic [CQ_DATA_W-1:0] tdata;
        logic [CQ_USER_W-1:0] tuser;
        logic                 tlast;
        logic [CQ_KEEP_W-1:0] tkeep;
    } cq_beat_t;

endpackage

// File: rtl/cpm5_cq_rx_fifo.sv
// Synchronous show-ahead FIFO of CQ beats with occupancy output.
module cpm5_cq_rx_fifo
    import cpm5_cq_rx_pkg::*;
#(
    parameter int DEPTH = CQ_CRED_DEPTH,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  cq_beat_t      beat_i,
    input  logic          pop_i,
    output cq_beat_t      beat_o,
    output logic          valid_o,
    output logic          full_o,
    output logic [LW-1:0] level_o
);

    localparam int PW = $clog2(DEPTH);

    cq_beat_t      mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          valid_q;
    logic          wr_en;
    logic          rd_en;

    assign full_o  = (level_q == LW'(DEPTH));
    assign rd_en   = pop_i & valid_q;
    // A full FIFO still accepts a beat when the head leaves in the same cycle
    assign wr_en   = push_i & (~full_o | rd_en);
    assign beat_o  = mem_q[rd_ptr_q];
    assign valid_o = valid_q;
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= beat_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            level_q <= level_d;
            valid_q <= (level_d != '0);
        end
    end

endmodule

// File: rtl/cpm5_cq_credit_rx.sv
// CPM5 CQ credit receiver: buffers beats, returns credits, AXIS master out.
// Optional CPM5_CQ_CREDIT_STATS_EN adds stat_beats/stat_tlps/stat_max_level.
module cpm5_cq_credit_rx
    import cpm5_cq_rx_pkg::*;
#(
    parameter int DATA_W = CQ_DATA_W,
    parameter int USER_W = CQ_USER_W,
    parameter int KEEP_W = CQ_KEEP_W,
    parameter int DEPTH  = CQ_CRED_DEPTH
) (
    input  logic                         axi_aclk,
    input  logic                         axi_aresetn,
    input  logic [DATA_W-1:0]            s_axis_cq_tdata,
    input  logic [USER_W-1:0]            s_axis_cq_tuser,
    input  logic                         s_axis_cq_tlast,
    input  logic [KEEP_W-1:0]            s_axis_cq_tkeep,
    input  logic                         s_axis_cq_tvalid,
    output logic                         s_axis_cq_credit,
    output logic [DATA_W-1:0]            m_axis_cq_tdata,
    output logic [USER_W-1:0]            m_axis_cq_tuser,
    output logic                         m_axis_cq_tlast,
    output logic [KEEP_W-1:0]            m_axis_cq_tkeep,
    output logic                         m_axis_cq_tvalid,
    input  logic                         m_axis_cq_tready,
    input  logic                         credit_en,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         err_overflow,
`ifdef CPM5_CQ_CREDIT_STATS_EN
    output logic [31:0]                  stat_beats,
    output logic [31:0]                  stat_tlps,
    output logic [$clog2(DEPTH+1)-1:0]   stat_max_level,
`endif
    input  logic                         err_clr
);

    localparam int LW = $clog2(DEPTH + 1);

    cq_beat_t      beat_in;
    cq_beat_t      beat_out;
    logic          pop;
    logic          full;
    logic [LW-1:0] level;
    logic          ovf;

    logic [LW-1:0] cred_pend_q;
    logic [LW-1:0] cred_pend_d;
    logic          credit_q;
    logic          credit_d;
    logic          err_q;
    logic          err_d;

    always_comb begin
        beat_in       = '0;
        beat_in.tdata = s_axis_cq_tdata;
        beat_in.tuser = s_axis_cq_tuser;
        beat_in.tlast = s_axis_cq_tlast;
        beat_in.tkeep = s_axis_cq_tkeep;
    end

    cpm5_cq_rx_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk_i   (axi_aclk),
        .rst_ni  (axi_aresetn),
        .push_i  (s_axis_cq_tvalid),
        .beat_i  (beat_in),
        .pop_i   (m_axis_cq_tready),
        .beat_o  (beat_out),
        .valid_o (m_axis_cq_tvalid),
        .full_o  (full),
        .level_o (level)
    );

    assign pop             = m_axis_cq_tvalid & m_axis_cq_tready;
    assign ovf             = s_axis_cq_tvalid & full & ~pop;
    assign m_axis_cq_tdata = beat_out.tdata;
    assign m_axis_cq_tuser = beat_out.tuser;
    assign m_axis_cq_tlast = beat_out.tlast;
    assign m_axis_cq_tkeep = beat_out.tkeep;
    assign fifo_level      = level;
    assign s_axis_cq_credit = credit_q;
    assign err_overflow    = err_q;

    // A slot freed this cycle may be credited back immediately
    always_comb begin
        credit_d    = credit_en & ((cred_pend_q != '0) | pop);
        cred_pend_d = cred_pend_q;
        unique case ({pop, credit_d})
            2'b10:   cred_pend_d = cred_pend_q + LW'(1);
            2'b01:   cred_pend_d = cred_pend_q - LW'(1);
            default: cred_pend_d = cred_pend_q;
        endcase
        err_d = ovf | (err_q & ~err_clr);
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            cred_pend_q <= LW'(DEPTH);
            credit_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cred_pend_q <= cred_pend_d;
            credit_q    <= credit_d;
            err_q       <= err_d;
        end
    end

`ifdef CPM5_CQ_CREDIT_STATS_EN
    logic          acc;
    logic [31:0]   beats_q;
    logic [31:0]   beats_d;
    logic [31:0]   tlps_q;
    logic [31:0]   tlps_d;
    logic [LW-1:0] max_q;
    logic [LW-1:0] max_d;

    assign acc = s_axis_cq_tvalid & (~full | pop);

    always_comb begin
        beats_d = beats_q + 32'(acc);
        tlps_d  = tlps_q + 32'(acc & s_axis_cq_tlast);
        max_d   = (level > max_q) ? level : max_q;
        if (err_clr) begin
            beats_d = '0;
            tlps_d  = '0;
            max_d   = '0;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            beats_q <= '0;
            tlps_q  <= '0;
            max_q   <= '0;
        end else begin
            beats_q <= beats_d;
            tlps_q  <= tlps_d;
            max_q   <= max_d;
        end
    end

    assign stat_beats     = beats_q;
    assign stat_tlps      = tlps_q;
    assign stat_max_level = max_q;
`endif

endmodule

// File: tb/tb_cpm5_cq_credit_rx.sv
// Scoreboard bench for cpm5_cq_credit_rx.
module tb_cpm5_cq_credit_rx;
  import cpm5_cq_rx_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CQ_DATA_W-1:0] s_tdata = '0;
  logic [CQ_USER_W-1:0] s_tuser = '0;
  logic s_tlast = 1'b0;
  logic [CQ_KEEP_W-1:0] s_tkeep = '0;
  logic s_tvalid = 1'b0;
  logic s_credit;
  logic [CQ_DATA_W-1:0] m_tdata;
  logic [CQ_USER_W-1:0] m_tuser;
  logic m_tlast;
  logic [CQ_KEEP_W-1:0] m_tkeep;
  logic m_tvalid;
  logic m_tready = 1'b0;
  logic credit_en = 1'b1;
  logic [LW-1:0] level;
  logic err;
  logic err_clr = 1'b0;
`ifdef CPM5_CQ_CREDIT_STATS_EN
  logic [31:0] st_beats;
  logic [31:0] st_tlps;
  logic [LW-1:0] st_max;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cred_cnt = 0;
  int seq = 0;
  cq_beat_t exp_q[$];

  cpm5_cq_credit_rx dut (
    .axi_aclk(clk),
    .axi_aresetn(rst_n),
    .s_axis_cq_tdata(s_tdata),
    .s_axis_cq_tuser(s_tuser),
    .s_axis_cq_tlast(s_tlast),
    .s_axis_cq_tkeep(s_tkeep),
    .s_axis_cq_tvalid(s_tvalid),
    .s_axis_cq_credit(s_credit),
    .m_axis_cq_tdata(m_tdata),
    .m_axis_cq_tuser(m_tuser),
    .m_axis_cq_tlast(m_tlast),
    .m_axis_cq_tkeep(m_tkeep),
    .m_axis_cq_tvalid(m_tvalid),
    .m_axis_cq_tready(m_tready),
    .credit_en(credit_en),
    .fifo_level(level),
    .err_overflow(err),
`ifdef CPM5_CQ_CREDIT_STATS_EN
    .stat_beats(st_beats),
    .stat_tlps(st_tlps),
    .stat_max_level(st_max),
`endif
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic cq_beat_t gen_beat(int n, logic last);
    cq_beat_t b;
    logic [31:0] w;
    w = 32'h9E37_0000 ^ (n * 32'h0100_0193);
    b.tdata = {32{w}};
    b.tdata[31:0] = 32'(n);
    b.tuser = CQ_USER_W'({15{~w}});
    b.tlast = last;
    b.tkeep = w ^ 32'(n);
    return b;
  endfunction

  task automatic drive(input logic v, input cq_beat_t b);
    @(posedge clk);
    #1;
    s_tvalid = v;
    s_tdata = b.tdata;
    s_tuser = b.tuser;
    s_tlast = b.tlast;
    s_tkeep = b.tkeep;
  endtask

  always @(negedge clk) begin
    cq_beat_t got;
    cq_beat_t exp;
    if (rst_n) begin
      if (s_credit) cred_cnt++;
      if (m_tvalid && m_tready) begin
        n_vec++;
        got.tdata = m_tdata;
        got.tuser = m_tuser;
        got.tlast = m_tlast;
        got.tkeep = m_tkeep;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pop_unexpected got=%h want=none", m_tdata[31:0]);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL beat got=%h/%b/%h want=%h/%b/%h",
              got.tdata[31:0], got.tlast, got.tkeep,
              exp.tdata[31:0], exp.tlast, exp.tkeep);
          end
        end
      end
    end
  end

  task automatic test_reset;
    #2;
    n_vec++;
    if ({s_credit, m_tvalid, level, err} !== '0 || m_tdata !== '0) begin
      n_err++;
      $display("FAIL reset_outs got=%b%b%0d%b want=0000",
        s_credit, m_tvalid, level, err);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_credit_burst;
    logic e;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      e = (i <= 16);
      n_vec++;
      if (s_credit !== e) begin
        n_err++;
        $display("FAIL burst_credit c%0d got=%b want=%b", i, s_credit, e);
      end
    end
    n_vec++;
    if (level !== 5'd0) begin
      n_err++;
      $display("FAIL burst_level got=%0d want=0", level);
    end
  endtask

  task automatic test_fill_drain;
    cq_beat_t b;
    logic prev;
    cred_cnt = 0;
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b = gen_beat(seq++, i == 15);
      drive(1'b1, b);
      exp_q.push_back(b);
    end
    drive(1'b0, '0);
    @(negedge clk);
    n_vec++;
    if (level !== 5'd16 || cred_cnt != 0 || m_tvalid !== 1'b1) begin
      n_err++;
      $display("FAIL fill got=%0d/%0d/%b want=16/0/1", level, cred_cnt, m_tvalid);
    end
    @(posedge clk);
    #1 m_tready = 1'b1;
    prev = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      n_vec++;
      if (s_credit !== prev) begin
        n_err++;
        $display("FAIL drain_credit k%0d got=%b want=%b", k, s_credit, prev);
      end
      prev = m_tvalid & m_tready;
    end
    n_vec++;
    if (exp_q.size() != 0 || level !== 5'd0 || cred_cnt != 16) begin
      n_err++;
      $display("FAIL drain_end got=%0d/%0d/%0d want=0/0/16",
        exp_q.size(), level, cred_cnt);
    end
  endtask

  task automatic test_stream;
    cq_beat_t b;
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b = gen_beat(seq++, (i % 4) == 3);
      drive(1'b1, b);
      exp_q.push_back(b);
      @(negedge clk);
      if (i >= 1) begin
        n_vec++;
        if (level !== 5'd1) begin
          n_err++;
          $display("FAIL stream_level i%0d got=%0d want=1", i, level);
        end
      end
      if (i >= 2) begin
        n_vec++;
        if (s_credit !== 1'b1) begin
          n_err++;
          $display("FAIL stream_credit i%0d got=%b want=1", i, s_credit);
        end
      end
    end
    drive(1'b0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0 || level !== 5'd0) begin
      n_err++;
      $display("FAIL stream_end got=%0d/%0d want=0/0", exp_q.size(), level);
    end
  endtask

  task automatic test_overflow;
    cq_beat_t b;
    int t;
    @(posedge clk);
    #1 m_tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = gen_beat(seq++, 1'b0);
      drive(1'b1, b);
      if (i < 16) exp_q.push_back(b);
    end
    drive(1'b0, '0);
    @(negedge clk);
    n_vec++;
    if (err !== 1'b1 || level !== 5'd16) begin
      n_err++;
      $display("FAIL ovf_set got=%b/%0d want=1/16", err, level);
    end
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr got=%b want=0", err);
    end
    b = gen_beat(seq++, 1'b1);
    drive(1'b1, b);
    err_clr = 1'b1;
    drive(1'b0, '0);
    err_clr = 1'b0;
    @(negedge clk);
    n_vec++;
    if (err !== 1'b1 || level !== 5'd16) begin
      n_err++;
      $display("FAIL ovf_clr_race got=%b/%0d want=1/16", err, level);
    end
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    b = gen_beat(seq++, 1'b1);
    drive(1'b1, b);
    m_tready = 1'b1;
    exp_q.push_back(b);
    drive(1'b0, '0);
    @(negedge clk);
    n_vec++;
    if (err !== 1'b0 || level !== 5'd16) begin
      n_err++;
      $display("FAIL full_push_pop got=%b/%0d want=0/16", err, level);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0 || m_tvalid !== 1'b0 || level !== 5'd0) begin
      n_err++;
      $display("FAIL ovf_drain got=%0d/%b/%0d want=0/0/0",
        exp_q.size(), m_tvalid, level);
    end
  endtask

  task automatic test_credit_en;
    @(posedge clk);
    #1;
    credit_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (s_credit !== 1'b0) begin
        n_err++;
        $display("FAIL cen_hold c%0d got=%b want=0", i, s_credit);
      end
    end
    @(posedge clk);
    #1;
    credit_en = 1'b1;
    cred_cnt = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (cred_cnt != 16) begin
      n_err++;
      $display("FAIL cen_release got=%0d want=16", cred_cnt);
    end
  endtask

  task automatic test_reset_mid;
    cq_beat_t b;
    m_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      b = gen_beat(seq++, i == 6);
      drive(1'b1, b);
      exp_q.push_back(b);
    end
    drive(1'b0, '0);
    @(negedge clk);
    n_vec++;
    if (level !== 5'd7) begin
      n_err++;
      $display("FAIL mid_level got=%0d want=7", level);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({s_credit, m_tvalid, level, err} !== '0 || m_tdata !== '0) begin
      n_err++;
      $display("FAIL mid_reset got=%b%b%0d%b want=0000",
        s_credit, m_tvalid, level, err);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cred_cnt = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (cred_cnt != 16 || level !== 5'd0) begin
      n_err++;
      $display("FAIL mid_recredit got=%0d/%0d want=16/0", cred_cnt, level);
    end
  endtask

`ifdef CPM5_CQ_CREDIT_STATS_EN
  task automatic test_stats;
    cq_beat_t b;
    int lvl;
    int mx;
    int t;
    logic rdy;
    n_vec++;
    if (st_beats !== 32'd0 || st_tlps !== 32'd0 || st_max !== 5'd0) begin
      n_err++;
      $display("FAIL stats_reset got=%0d/%0d/%0d want=0/0/0",
        st_beats, st_tlps, st_max);
    end
    lvl = 0;
    mx = 0;
    for (int i = 0; i < 15; i++) begin
      b = gen_beat(seq++, (i % 3) == 2);
      rdy = ((i % 3) == 2);
      drive(1'b1, b);
      m_tready = rdy;
      exp_q.push_back(b);
      lvl = lvl + 1 - ((lvl > 0 && rdy) ? 1 : 0);
      if (lvl > mx) mx = lvl;
    end
    drive(1'b0, '0);
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (st_beats !== 32'd15 || st_tlps !== 32'd5 || st_max !== 5'(mx)) begin
      n_err++;
      $display("FAIL stats got=%0d/%0d/%0d want=15/5/%0d",
        st_beats, st_tlps, st_max, mx);
    end
    @(posedge clk);
    #1 m_tready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0 || st_beats !== 32'd0 || st_max !== 5'd0) begin
      n_err++;
      $display("FAIL stats_clr got=%0d/%0d/%0d want=0/0/0",
        exp_q.size(), st_beats, st_max);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL timeout got=running want=done");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_credit_burst();
    test_fill_drain();
    test_stream();
    test_overflow();
    test_credit_en();
    test_reset_mid();
`ifdef CPM5_CQ_CREDIT_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
